// File: rtl/mcp_resp_send.sv
// Transmit side of the b->a MCP toggle handshake: queues b-side response words and launches each one
// with an r_en toggle. The a_ack toggle completes the transfer. Optional ack watchdog: MCP_TIMEOUT_EN.
module mcp_resp_send #(
  parameter int BUS_LEN        = 40,
  parameter int DEPTH          = 2,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               bclk,
  input  logic               brst,
  input  logic [BUS_LEN-1:0] bdatain,
  input  logic               bsend,
  output logic               bready,
  output logic [BUS_LEN-1:0] rdata,
  output logic               r_en,
  input  logic               a_ack,
  output logic               bbusy,
  output logic               berr
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_WAIT_ACK = 1'b1
  } state_t;

  state_t                   state_q;
  logic [SYNC_STAGES-1:0]   ack_sync_q;
  logic                     ack_s_q;
  logic                     ack_s_s;
  logic                     ack_p_s;

  logic [BUS_LEN-1:0]       mem_q [DEPTH];
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic                     push_s;
  logic                     pop_s;

  logic [BUS_LEN-1:0]       rdata_q;
  logic                     r_en_q;
  logic                     bbusy_q;

  assign ack_s_s = ack_sync_q[SYNC_STAGES-1];
  assign ack_p_s = ack_s_s ^ ack_s_q;

  assign bready  = (count_q < CNT_FULL);
  assign push_s  = bsend & bready;
  assign pop_s   = (state_q == ST_IDLE) && (count_q != {CNT_W{1'b0}});

  assign rdata   = rdata_q;
  assign r_en    = r_en_q;
  assign bbusy   = bbusy_q;

  // Ack synchroniser chain plus the edge-history flop that turns the toggle into a pulse.
  always_ff @(posedge bclk) begin
    if (brst) begin
      ack_sync_q <= {SYNC_STAGES{1'b0}};
      ack_s_q    <= 1'b0;
    end else begin
      ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], a_ack};
      ack_s_q    <= ack_s_s;
    end
  end

  // Queue pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? {PTR_W{1'b0}} : (wr_ptr_q + PTR_W'(1));
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? {PTR_W{1'b0}} : (rd_ptr_q + PTR_W'(1));
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Queue storage and pointer registers.
  always_ff @(posedge bclk) begin
    if (brst) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {BUS_LEN{1'b0}};
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_s) begin
        mem_q[wr_ptr_q] <= bdatain;
      end
    end
  end

  // Handshake FSM; rdata only moves on a launch so it is stable across the multi-cycle window.
  always_ff @(posedge bclk) begin
    if (brst) begin
      state_q <= ST_IDLE;
      rdata_q <= {BUS_LEN{1'b0}};
      r_en_q  <= 1'b0;
      bbusy_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pop_s) begin
            rdata_q <= mem_q[rd_ptr_q];
            r_en_q  <= ~r_en_q;
            bbusy_q <= 1'b1;
            state_q <= ST_WAIT_ACK;
          end
        end
        ST_WAIT_ACK: begin
          if (ack_p_s) begin
            bbusy_q <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          bbusy_q <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef MCP_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT_CYCLES);

  logic [TO_W-1:0] wait_cnt_q;
  logic            berr_q;

  // Ack watchdog: flags a missing ack but keeps waiting, so no word is ever dropped.
  always_ff @(posedge bclk) begin
    if (brst) begin
      wait_cnt_q <= {TO_W{1'b0}};
      berr_q     <= 1'b0;
    end else if (pop_s) begin
      wait_cnt_q <= {TO_W{1'b0}};
    end else if (state_q == ST_WAIT_ACK) begin
      if (wait_cnt_q != TO_LIM) begin
        wait_cnt_q <= wait_cnt_q + TO_W'(1);
      end
      if (wait_cnt_q >= (TO_LIM - TO_W'(1))) begin
        berr_q <= 1'b1;
      end
    end
  end

  assign berr = berr_q;
`else
  // Constant 0: the watchdog limit only matters when the counter is built.
  assign berr = (TIMEOUT_CYCLES < 0);
`endif

endmodule

// File: tb/tb_mcp_resp_send.sv
// Directed self-checking bench for mcp_resp_send (DEPTH=2, SYNC_STAGES=2, TIMEOUT_CYCLES=16).
module tb_mcp_resp_send;

  localparam int BUS_LEN = 40;

  logic               bclk = 1'b0;
  logic               brst = 1'b1;
  logic [BUS_LEN-1:0] bdatain = {BUS_LEN{1'b0}};
  logic               bsend = 1'b0;
  logic               bready;
  logic [BUS_LEN-1:0] rdata;
  logic               r_en;
  logic               a_ack = 1'b0;
  logic               bbusy;
  logic               berr;

  int n_total = 0;
  int n_bad   = 0;
  int flips   = 0;
  int flips_start;
  logic r_en_prev = 1'b0;
  logic exp_ren   = 1'b0;
  logic exp_berr;

  mcp_resp_send #(
    .BUS_LEN(BUS_LEN), .DEPTH(2), .SYNC_STAGES(2), .TIMEOUT_CYCLES(16)
  ) dut (
    .bclk(bclk), .brst(brst), .bdatain(bdatain), .bsend(bsend), .bready(bready),
    .rdata(rdata), .r_en(r_en), .a_ack(a_ack), .bbusy(bbusy), .berr(berr)
  );

  always #5 bclk = ~bclk;

  always @(negedge bclk) begin
    if (r_en !== r_en_prev) flips = flips + 1;
    r_en_prev = r_en;
  end

  task automatic tick();
    @(posedge bclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total = n_total + 1;
    if (got !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [BUS_LEN-1:0] w);
    bdatain = w;
    bsend   = 1'b1;
    tick();
    bsend   = 1'b0;
  endtask

  task automatic ack_wait();
    a_ack = ~a_ack;
    repeat (3) tick();
  endtask

  initial begin
    // 1 reset
    brst = 1'b1;
    repeat (3) tick();
    chk("rst_rdata", 64'(rdata), 64'h0);
    chk("rst_ren",   64'(r_en),  64'h0);
    chk("rst_busy",  64'(bbusy), 64'h0);
    chk("rst_berr",  64'(berr),  64'h0);
    brst = 1'b0;
    tick();
    chk("rst_ready", 64'(bready), 64'h1);

    // 2 single word
    push(40'hA5_5A5A_5A5A);
    chk("sw_ren_pre",  64'(r_en),  64'h0);
    chk("sw_busy_pre", 64'(bbusy), 64'h0);
    tick();
    exp_ren = ~exp_ren;
    chk("sw_ren",   64'(r_en),  64'(exp_ren));
    chk("sw_rdata", 64'(rdata), 64'hA5_5A5A_5A5A);
    chk("sw_busy",  64'(bbusy), 64'h1);
    a_ack = ~a_ack;
    tick();
    tick();
    chk("sw_busy_hold", 64'(bbusy), 64'h1);
    tick();
    chk("sw_busy_done", 64'(bbusy), 64'h0);
    chk("sw_rdata_hold", 64'(rdata), 64'hA5_5A5A_5A5A);

    // 3 backpressure
    flips_start = flips;
    push(40'h1);
    push(40'h2);
    push(40'h3);
    exp_ren = ~exp_ren;
    chk("bp_ready", 64'(bready), 64'h0);
    chk("bp_rdata1", 64'(rdata), 64'h1);
    chk("bp_ren1", 64'(r_en), 64'(exp_ren));
    push(40'h4);
    chk("bp_ready2", 64'(bready), 64'h0);
    ack_wait();
    tick();
    exp_ren = ~exp_ren;
    chk("bp_rdata2", 64'(rdata), 64'h2);
    chk("bp_ren2", 64'(r_en), 64'(exp_ren));
    chk("bp_ready3", 64'(bready), 64'h1);
    ack_wait();
    tick();
    exp_ren = ~exp_ren;
    chk("bp_rdata3", 64'(rdata), 64'h3);
    ack_wait();
    tick();
    chk("bp_idle", 64'(bbusy), 64'h0);
    chk("bp_rdata_end", 64'(rdata), 64'h3);
    chk("bp_flips", 64'(flips - flips_start), 64'd3);

    // 4 push and pop in the same cycle
    push(40'h11);
    tick();
    exp_ren = ~exp_ren;
    push(40'h22);
    a_ack = ~a_ack;
    repeat (3) tick();
    chk("pp_idle", 64'(bbusy), 64'h0);
    push(40'h33);
    exp_ren = ~exp_ren;
    chk("pp_rdata_y", 64'(rdata), 64'h22);
    chk("pp_busy", 64'(bbusy), 64'h1);
    chk("pp_ready", 64'(bready), 64'h1);
    ack_wait();
    tick();
    exp_ren = ~exp_ren;
    chk("pp_rdata_z", 64'(rdata), 64'h33);
    chk("pp_ren_z", 64'(r_en), 64'(exp_ren));
    ack_wait();
    tick();
    chk("pp_done", 64'(bbusy), 64'h0);

    // 5 spurious ack in IDLE
    a_ack = ~a_ack;
    repeat (4) tick();
    chk("sp_ren", 64'(r_en), 64'(exp_ren));
    chk("sp_busy", 64'(bbusy), 64'h0);
    push(40'h5A);
    tick();
    exp_ren = ~exp_ren;
    chk("sp_rdata", 64'(rdata), 64'h5A);
    chk("sp_ren2", 64'(r_en), 64'(exp_ren));
    ack_wait();
    chk("sp_done", 64'(bbusy), 64'h0);

    // 6 reset mid-transfer
    push(40'h77);
    tick();
    push(40'h88);
    chk("mr_busy_pre", 64'(bbusy), 64'h1);
    brst  = 1'b1;
    a_ack = 1'b0;
    repeat (2) tick();
    brst  = 1'b0;
    exp_ren = 1'b0;
    chk("mr_busy", 64'(bbusy), 64'h0);
    chk("mr_ren", 64'(r_en), 64'h0);
    chk("mr_rdata", 64'(rdata), 64'h0);
    chk("mr_ready", 64'(bready), 64'h1);
    repeat (3) tick();
    chk("mr_nolaunch_ren", 64'(r_en), 64'h0);
    chk("mr_nolaunch_busy", 64'(bbusy), 64'h0);

    // ack watchdog (berr stays 0 when the feature is not built)
`ifdef MCP_TIMEOUT_EN
    exp_berr = 1'b1;
`else
    exp_berr = 1'b0;
`endif
    push(40'h99);
    tick();
    exp_ren = ~exp_ren;
    repeat (15) tick();
    chk("to_berr_early", 64'(berr), 64'h0);
    tick();
    chk("to_berr", 64'(berr), 64'(exp_berr));
    chk("to_still_busy", 64'(bbusy), 64'h1);
    ack_wait();
    chk("to_late_ack", 64'(bbusy), 64'h0);
    chk("to_berr_sticky", 64'(berr), 64'(exp_berr));
    chk("to_ren", 64'(r_en), 64'(exp_ren));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
